// File: rtl/pu_or1k_pic_sched_if.sv
// Bundle of PIC scheduler signals: pending IRQs, CPU request/ack handshake and SPR bus.
// The scheduler is the slave on both the SPR bus and the interrupt handshake.
interface pu_or1k_pic_sched_if;
    logic [31:0] picsr_i;
    logic        cpu_irq_en_i;
    logic        cpu_irq_ack_i;
    logic        irq_req_o;
    logic [4:0]  irq_vec_o;
    logic [1:0]  irq_prio_o;
    logic [31:0] isr_o;
    logic        spr_access_i;
    logic        spr_we_i;
    logic [15:0] spr_addr_i;
    logic [31:0] spr_dat_i;
    logic        spr_bus_ack;
    logic [31:0] spr_dat_o;

    modport slave (
        input  picsr_i, cpu_irq_en_i, cpu_irq_ack_i,
        input  spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
        output irq_req_o, irq_vec_o, irq_prio_o, isr_o,
        output spr_bus_ack, spr_dat_o
    );

    modport master (
        output picsr_i, cpu_irq_en_i, cpu_irq_ack_i,
        output spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
        input  irq_req_o, irq_vec_o, irq_prio_o, isr_o,
        input  spr_bus_ack, spr_dat_o
    );
endinterface

// File: rtl/pu_or1k_pic_sched.sv
// OR1K PIC priority scheduler: nested vectored IRQ requests with in-service tracking and EOI.
// Optional macro PU_OR1K_PIC_SCHED_ROUND_ROBIN_EN: round-robin tie breaking within a priority.
module pu_or1k_pic_sched #(
    parameter int unsigned OPTION_SCHED_TIMEOUT  = 255,
    parameter logic [1:0]  OPTION_SCHED_PRIO_RST = 2'd0
) (
    input  logic               clk,
    input  logic               rst,
    pu_or1k_pic_sched_if.slave bus
);

    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [4:0]  SPR_GROUP_PIC = 5'd9;
    localparam logic [10:0] OFF_PRIO0 = 11'h010;
    localparam logic [10:0] OFF_PRIO1 = 11'h011;
    localparam logic [10:0] OFF_ISR   = 11'h012;
    localparam logic [10:0] OFF_EOI   = 11'h013;
    localparam logic [10:0] OFF_STAT  = 11'h014;
    localparam logic [7:0]  TO_LAST   = 8'(OPTION_SCHED_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [63:0] prio_q;
    logic [31:0] isr_q, isr_d;
    logic [4:0]  vec_q;
    logic [1:0]  prio_lat_q;
    logic [7:0]  cnt_q;
    logic        stat_to_q;
    logic [4:0]  stat_last_q;
`ifdef PU_OR1K_PIC_SCHED_ROUND_ROBIN_EN
    logic [4:0]  rr_ptr_q;
`endif

    logic        spr_sel, spr_wr;
    logic [10:0] spr_off;
    logic        wr_prio0, wr_prio1, wr_eoi, wr_stat;
    logic        run_valid;
    logic [1:0]  run_lvl;
    logic [31:0] elig;
    logic        found;
    logic [4:0]  win_vec;
    logic [1:0]  win_prio;
    logic        irq_req;
    logic        latch_evt, ack_evt, timeout_evt;

    assign spr_sel  = bus.spr_access_i && (bus.spr_addr_i[15:11] == SPR_GROUP_PIC);
    assign spr_off  = bus.spr_addr_i[10:0];
    assign spr_wr   = spr_sel && bus.spr_we_i;
    assign wr_prio0 = spr_wr && (spr_off == OFF_PRIO0);
    assign wr_prio1 = spr_wr && (spr_off == OFF_PRIO1);
    assign wr_eoi   = spr_wr && (spr_off == OFF_EOI);
    assign wr_stat  = spr_wr && (spr_off == OFF_STAT);

    // Running level is the highest priority still in service; only strictly higher may nest.
    always_comb begin
        run_valid = 1'b0;
        run_lvl   = 2'd0;
        elig      = '0;
        for (int i = 0; i < 32; i++) begin
            if (isr_q[i] && (!run_valid || prio_q[2*i +: 2] > run_lvl)) begin
                run_valid = 1'b1;
                run_lvl   = prio_q[2*i +: 2];
            end
        end
        for (int i = 0; i < 32; i++) begin
            elig[i] = bus.picsr_i[i] && !isr_q[i] &&
                      (!run_valid || prio_q[2*i +: 2] > run_lvl);
        end
    end

    // Strict '>' keeps the first line found at a level, so the scan start decides ties.
    always_comb begin
        logic [4:0] idx;
        found    = 1'b0;
        win_vec  = 5'd0;
        win_prio = 2'd0;
        idx      = 5'd0;
        for (int k = 0; k < 32; k++) begin
`ifdef PU_OR1K_PIC_SCHED_ROUND_ROBIN_EN
            idx = rr_ptr_q + 5'(k);
`else
            idx = 5'(k);
`endif
            if (elig[idx] && (!found || prio_q[2*idx +: 2] > win_prio)) begin
                found    = 1'b1;
                win_vec  = idx;
                win_prio = prio_q[2*idx +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.cpu_irq_en_i && found) state_d = REQ;
            REQ: begin
                if (bus.cpu_irq_ack_i)          state_d = IDLE;
                else if (!bus.picsr_i[vec_q])   state_d = IDLE;
                else if (cnt_q == TO_LAST)      state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq_req     = (state_q == REQ);
        latch_evt   = (state_q == IDLE) && bus.cpu_irq_en_i && found;
        ack_evt     = (state_q == REQ) && bus.cpu_irq_ack_i;
        timeout_evt = (state_q == REQ) && !bus.cpu_irq_ack_i &&
                      bus.picsr_i[vec_q] && (cnt_q == TO_LAST);
    end

    // EOI clears before ack sets, so a same-cycle EOI/ack of one vector leaves it in service.
    always_comb begin
        isr_d = isr_q;
        if (wr_eoi)  isr_d[bus.spr_dat_i[4:0]] = 1'b0;
        if (ack_evt) isr_d[vec_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q      <= {32{OPTION_SCHED_PRIO_RST}};
            isr_q       <= '0;
            vec_q       <= 5'd0;
            prio_lat_q  <= 2'd0;
            cnt_q       <= 8'd0;
            stat_to_q   <= 1'b0;
            stat_last_q <= 5'd0;
        end else begin
            isr_q <= isr_d;
            if (wr_prio0) prio_q[31:0]  <= bus.spr_dat_i;
            if (wr_prio1) prio_q[63:32] <= bus.spr_dat_i;
            if (latch_evt) begin
                vec_q      <= win_vec;
                prio_lat_q <= win_prio;
                cnt_q      <= 8'd0;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q + 8'd1;
            end
            stat_to_q <= (stat_to_q && !(wr_stat && bus.spr_dat_i[0])) || timeout_evt;
            if (ack_evt) stat_last_q <= vec_q;
        end
    end

`ifdef PU_OR1K_PIC_SCHED_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         rr_ptr_q <= 5'd0;
        else if (ack_evt) rr_ptr_q <= vec_q + 5'd1;
    end
`endif

    always_comb begin
        bus.spr_dat_o = 32'd0;
        if (spr_sel) begin
            case (spr_off)
                OFF_PRIO0: bus.spr_dat_o = prio_q[31:0];
                OFF_PRIO1: bus.spr_dat_o = prio_q[63:32];
                OFF_ISR:   bus.spr_dat_o = isr_q;
                OFF_STAT:  bus.spr_dat_o = {26'd0, stat_last_q, stat_to_q};
                default:   bus.spr_dat_o = 32'd0;
            endcase
        end
    end

    assign bus.spr_bus_ack = bus.spr_access_i;
    assign bus.irq_req_o   = irq_req;
    assign bus.irq_vec_o   = vec_q;
    assign bus.irq_prio_o  = prio_lat_q;
    assign bus.isr_o       = isr_q;

endmodule

// File: tb/tb_pu_or1k_pic_sched.sv
// Directed self-checking bench for pu_or1k_pic_sched (timeout 8, reset priority 1).
// Covers priority pick, nesting, ties, withdrawal, timeout, EOI/ack ordering and async reset.
module tb_pu_or1k_pic_sched;
    localparam logic [15:0] A_PRIO0  = 16'h4810;
    localparam logic [15:0] A_PRIO1  = 16'h4811;
    localparam logic [15:0] A_ISR    = 16'h4812;
    localparam logic [15:0] A_EOI    = 16'h4813;
    localparam logic [15:0] A_STAT   = 16'h4814;
    localparam logic [15:0] A_UNUSED = 16'h4815;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] rd;
    int   high_cnt;
    logic [4:0] tie_vec;

    pu_or1k_pic_sched_if bus ();

    pu_or1k_pic_sched #(
        .OPTION_SCHED_TIMEOUT (8),
        .OPTION_SCHED_PRIO_RST(2'd1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] picsr, input logic en, input logic ack);
        bus.picsr_i       = picsr;
        bus.cpu_irq_en_i  = en;
        bus.cpu_irq_ack_i = ack;
    endtask

    task automatic sprWrite(input logic [15:0] addr, input logic [31:0] data);
        bus.spr_access_i = 1'b1;
        bus.spr_we_i     = 1'b1;
        bus.spr_addr_i   = addr;
        bus.spr_dat_i    = data;
        step();
        bus.spr_access_i = 1'b0;
        bus.spr_we_i     = 1'b0;
    endtask

    task automatic sprRead(input logic [15:0] addr, output logic [31:0] data);
        bus.spr_access_i = 1'b1;
        bus.spr_we_i     = 1'b0;
        bus.spr_addr_i   = addr;
        #1;
        data = bus.spr_dat_o;
        bus.spr_access_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        applyStimulus(32'h0, 1'b1, 1'b0);
        bus.spr_access_i = 1'b0;
        bus.spr_we_i     = 1'b0;
        bus.spr_addr_i   = 16'h0;
        bus.spr_dat_i    = 32'h0;
        step();

        // Reset state
        checkOutput("rst_req", {31'd0, bus.irq_req_o}, 32'd0);
        checkOutput("rst_vec", {27'd0, bus.irq_vec_o}, 32'd0);
        checkOutput("rst_prio", {30'd0, bus.irq_prio_o}, 32'd0);
        checkOutput("rst_isr", bus.isr_o, 32'd0);
        sprRead(A_PRIO0, rd);
        checkOutput("rst_prio0", rd, 32'h5555_5555);
        sprRead(A_PRIO1, rd);
        checkOutput("rst_prio1", rd, 32'h5555_5555);
        sprRead(A_STAT, rd);
        checkOutput("rst_stat", rd, 32'd0);
        step();
        rst = 1'b1;

        // Unused offset and write-only EOI read as zero
        sprWrite(A_UNUSED, 32'hFFFF_FFFF);
        bus.spr_access_i = 1'b1;
        bus.spr_addr_i   = A_UNUSED;
        #1;
        checkOutput("bus_ack", {31'd0, bus.spr_bus_ack}, 32'd1);
        checkOutput("unused_rd", bus.spr_dat_o, 32'd0);
        bus.spr_access_i = 1'b0;
        sprRead(A_EOI, rd);
        checkOutput("eoi_rd", rd, 32'd0);

        // Priority pick: IRQ3=1, IRQ7=3
        sprWrite(A_PRIO1, 32'h0);
        sprWrite(A_PRIO0, 32'h0000_C040);
        sprRead(A_PRIO0, rd);
        checkOutput("prio0_rd", rd, 32'h0000_C040);
        applyStimulus(32'h88, 1'b1, 1'b0);
        #1;
        checkOutput("pick_req_early", {31'd0, bus.irq_req_o}, 32'd0);
        step();
        checkOutput("pick_req", {31'd0, bus.irq_req_o}, 32'd1);
        checkOutput("pick_vec", {27'd0, bus.irq_vec_o}, 32'd7);
        checkOutput("pick_prio", {30'd0, bus.irq_prio_o}, 32'd3);
        applyStimulus(32'h88, 1'b1, 1'b1);
        step();
        applyStimulus(32'h08, 1'b1, 1'b0);
        checkOutput("ack_req", {31'd0, bus.irq_req_o}, 32'd0);
        checkOutput("ack_isr", bus.isr_o, 32'h80);
        sprRead(A_STAT, rd);
        checkOutput("ack_stat", rd, 32'h0E);

        // Nesting: lower priority IRQ3 blocked while IRQ7 in service
        step();
        step();
        checkOutput("nest_block", {31'd0, bus.irq_req_o}, 32'd0);
        sprWrite(A_EOI, 32'd9);
        checkOutput("eoi_noop", bus.isr_o, 32'h80);
        sprWrite(A_EOI, 32'd7);
        checkOutput("eoi7_isr", bus.isr_o, 32'h0);
        step();
        checkOutput("nest_req", {31'd0, bus.irq_req_o}, 32'd1);
        checkOutput("nest_vec", {27'd0, bus.irq_vec_o}, 32'd3);
        checkOutput("nest_prio", {30'd0, bus.irq_prio_o}, 32'd1);
        applyStimulus(32'h08, 1'b1, 1'b1);
        step();
        applyStimulus(32'h0, 1'b1, 1'b0);
        checkOutput("nest_isr", bus.isr_o, 32'h08);
        sprWrite(A_EOI, 32'd3);
        checkOutput("eoi3_isr", bus.isr_o, 32'h0);

        // Tie: IRQ2 and IRQ5 both priority 2
        sprWrite(A_PRIO0, 32'h0000_0820);
        applyStimulus(32'h24, 1'b1, 1'b0);
        step();
        checkOutput("tie_vec1", {27'd0, bus.irq_vec_o}, 32'd2);
        checkOutput("tie_prio1", {30'd0, bus.irq_prio_o}, 32'd2);
        applyStimulus(32'h24, 1'b1, 1'b1);
        step();
        applyStimulus(32'h24, 1'b1, 1'b0);
        checkOutput("tie_isr", bus.isr_o, 32'h04);
        step();
        checkOutput("tie_equal_block", {31'd0, bus.irq_req_o}, 32'd0);
        sprWrite(A_EOI, 32'd2);
        step();
`ifdef PU_OR1K_PIC_SCHED_ROUND_ROBIN_EN
        tie_vec = 5'd5;
`else
        tie_vec = 5'd2;
`endif
        checkOutput("tie_req2", {31'd0, bus.irq_req_o}, 32'd1);
        checkOutput("tie_vec2", {27'd0, bus.irq_vec_o}, {27'd0, tie_vec});
        applyStimulus(32'h24, 1'b1, 1'b1);
        step();
        applyStimulus(32'h0, 1'b1, 1'b0);
        sprWrite(A_EOI, {27'd0, tie_vec});
        checkOutput("tie_isr_clr", bus.isr_o, 32'h0);

        // Withdrawal: IRQ4 (priority 0) drops before ack
        applyStimulus(32'h10, 1'b1, 1'b0);
        step();
        checkOutput("wd_req", {31'd0, bus.irq_req_o}, 32'd1);
        checkOutput("wd_vec", {27'd0, bus.irq_vec_o}, 32'd4);
        applyStimulus(32'h0, 1'b1, 1'b0);
        step();
        checkOutput("wd_drop", {31'd0, bus.irq_req_o}, 32'd0);
        checkOutput("wd_isr", bus.isr_o, 32'h0);
        sprRead(A_STAT, rd);
        checkOutput("wd_stat_to", rd & 32'h1, 32'h0);

        // Timeout after 8 REQ cycles, then re-arbitration; enable low does not withdraw
        applyStimulus(32'h10, 1'b1, 1'b0);
        step();
        applyStimulus(32'h10, 1'b0, 1'b0);
        high_cnt = bus.irq_req_o ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!bus.irq_req_o) break;
            high_cnt++;
        end
        checkOutput("to_cycles", high_cnt, 32'd8);
        sprRead(A_STAT, rd);
        checkOutput("to_stat", rd & 32'h1, 32'h1);
        applyStimulus(32'h10, 1'b1, 1'b0);
        step();
        checkOutput("to_rearb", {31'd0, bus.irq_req_o}, 32'd1);

        // Same-cycle EOI and ack for vector 4 leaves it in service
        bus.spr_access_i = 1'b1;
        bus.spr_we_i     = 1'b1;
        bus.spr_addr_i   = A_EOI;
        bus.spr_dat_i    = 32'd4;
        applyStimulus(32'h10, 1'b1, 1'b1);
        step();
        bus.spr_access_i = 1'b0;
        bus.spr_we_i     = 1'b0;
        applyStimulus(32'h0, 1'b1, 1'b0);
        checkOutput("eoi_ack_isr", bus.isr_o, 32'h10);
        sprRead(A_STAT, rd);
        checkOutput("eoi_ack_stat", rd, 32'h09);
        sprWrite(A_STAT, 32'h1);
        sprRead(A_STAT, rd);
        checkOutput("stat_clr", rd, 32'h08);

        // Async reset while in REQ (IRQ2 prio 2 nests over IRQ4 prio 0)
        applyStimulus(32'h04, 1'b1, 1'b0);
        step();
        checkOutput("ar_req", {31'd0, bus.irq_req_o}, 32'd1);
        checkOutput("ar_vec", {27'd0, bus.irq_vec_o}, 32'd2);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("ar_req_low", {31'd0, bus.irq_req_o}, 32'd0);
        checkOutput("ar_isr", bus.isr_o, 32'h0);
        checkOutput("ar_vec0", {27'd0, bus.irq_vec_o}, 32'd0);
        sprRead(A_PRIO0, rd);
        checkOutput("ar_prio0", rd, 32'h5555_5555);
        sprRead(A_PRIO1, rd);
        checkOutput("ar_prio1", rd, 32'h5555_5555);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
